// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for a 5-stage in-order pipeline with
// ID-stage branch resolution and a multi-cycle data memory that freezes the pipe.
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  id_memwrite_i,
  input  logic                  id_branch_i,
  input  logic                  branch_eq_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  id_bubble_o,
  output logic                  if_flush_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic [1:0]            fwd_br1_o,
  output logic [1:0]            fwd_br2_o,
  output logic                  mem_busy_o,
  output logic [REG_ADDR_W-1:0] memwb_rd_o,
  output logic                  memwb_regwrite_o
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memaccess;
  } entry_t;

  localparam int IDEX  = 0;
  localparam int EXMEM = 1;
  localparam int MEMWB = 2;

  entry_t                pipe_reg [3];
  logic [REG_ADDR_W-1:0] src1_reg;
  logic [REG_ADDR_W-1:0] src2_reg;
  logic                  use1_reg;
  logic                  use2_reg;
  logic                  freeze;
  logic                  load_use;
  logic                  branch_stall;
  logic                  stall;

  function automatic logic hit(input entry_t e, input logic [REG_ADDR_W-1:0] src,
                               input logic use_src);
    return use_src && e.valid && e.regwrite && (e.rd != '0) && (e.rd == src);
  endfunction

  // no_load: a load still in EX/MEM cannot feed the ID-stage comparator
  function automatic logic [1:0] sel(input entry_t exmem, input entry_t memwb,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic use_src, input logic no_load);
    if (hit(exmem, src, use_src) && !(no_load && exmem.memread)) return 2'b10;
    if (hit(memwb, src, use_src)) return 2'b01;
    return 2'b00;
  endfunction

  generate
    if (MEM_LAT > 1) begin : g_lat
      localparam int CNT_W = $clog2(MEM_LAT);
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end else if (pipe_reg[IDEX].valid && pipe_reg[IDEX].memaccess) begin
          cnt_reg <= CNT_W'(MEM_LAT - 1);
        end
      end

      assign freeze = (cnt_reg != '0);
    end else begin : g_nolat
      assign freeze = 1'b0;
    end
  endgenerate

  always_comb begin
    load_use = pipe_reg[IDEX].memread &&
               (hit(pipe_reg[IDEX], id_rs1_i, id_use_rs1_i) ||
                hit(pipe_reg[IDEX], id_rs2_i, id_use_rs2_i));
    branch_stall = id_branch_i &&
                   (hit(pipe_reg[IDEX], id_rs1_i, id_use_rs1_i) ||
                    hit(pipe_reg[IDEX], id_rs2_i, id_use_rs2_i) ||
                    (pipe_reg[EXMEM].memread &&
                     (hit(pipe_reg[EXMEM], id_rs1_i, id_use_rs1_i) ||
                      hit(pipe_reg[EXMEM], id_rs2_i, id_use_rs2_i))));
    stall = load_use || branch_stall;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 3; i++) pipe_reg[i] <= '0;
      src1_reg <= '0;
      src2_reg <= '0;
      use1_reg <= 1'b0;
      use2_reg <= 1'b0;
    end else if (!freeze) begin
      pipe_reg[MEMWB] <= pipe_reg[EXMEM];
      pipe_reg[EXMEM] <= pipe_reg[IDEX];
      src1_reg        <= id_rs1_i;
      src2_reg        <= id_rs2_i;
      if (stall || !start_i) begin
        pipe_reg[IDEX] <= '0;
        use1_reg       <= 1'b0;
        use2_reg       <= 1'b0;
      end else begin
        pipe_reg[IDEX].valid     <= 1'b1;
        pipe_reg[IDEX].rd        <= id_rd_i;
        pipe_reg[IDEX].regwrite  <= id_regwrite_i;
        pipe_reg[IDEX].memread   <= id_memread_i;
        pipe_reg[IDEX].memaccess <= id_memread_i || id_memwrite_i;
        use1_reg                 <= id_use_rs1_i;
        use2_reg                 <= id_use_rs2_i;
      end
    end
  end

  // Priority: freeze over stall over flush; reset only lets start_i through
  always_comb begin
    pc_write_o    = start_i;
    if_id_write_o = start_i;
    id_bubble_o   = 1'b0;
    if_flush_o    = 1'b0;
    if (!rst_i) begin
      if (freeze) begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
      end else if (stall) begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        id_bubble_o   = 1'b1;
      end else if (id_branch_i && branch_eq_i) begin
        if_flush_o = 1'b1;
      end
    end
  end

  assign fwd_a_o          = sel(pipe_reg[EXMEM], pipe_reg[MEMWB], src1_reg, use1_reg, 1'b0);
  assign fwd_b_o          = sel(pipe_reg[EXMEM], pipe_reg[MEMWB], src2_reg, use2_reg, 1'b0);
  assign fwd_br1_o        = sel(pipe_reg[EXMEM], pipe_reg[MEMWB], id_rs1_i, id_use_rs1_i, 1'b1);
  assign fwd_br2_o        = sel(pipe_reg[EXMEM], pipe_reg[MEMWB], id_rs2_i, id_use_rs2_i, 1'b1);
  assign mem_busy_o       = freeze;
  assign memwb_rd_o       = pipe_reg[MEMWB].rd;
  assign memwb_regwrite_o = pipe_reg[MEMWB].valid && pipe_reg[MEMWB].regwrite;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: one single-cycle-memory and one 4-cycle-memory instance
// share stimulus; directed table, freeze/reset sequences and random cycles vs a model.
module tb_hazard_fwd_ctrl;

  localparam int LAT4 = 4;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       ld;
    logic       st;
    logic       br;
    logic       eq;
  } stim_t;

  typedef struct packed {
    logic       pcw;
    logic       ifid;
    logic       bub;
    logic       flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] fbr1;
    logic [1:0] fbr2;
    logic       busy;
    logic [4:0] wb_rd;
    logic       wb_wr;
  } out_t;

  // one in-flight instruction as seen from the ID stage looking downstream
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       acc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } rec_t;

  typedef struct {
    stim_t      s;
    logic [8:0] exp;
  } row_t;

  logic clk = 1'b0;
  logic rst_i, start_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic id_use_rs1_i, id_use_rs2_i, id_regwrite_i, id_memread_i, id_memwrite_i;
  logic id_branch_i, branch_eq_i;

  logic pcw_1, ifid_1, bub_1, flush_1, busy_1, wbwr_1;
  logic [1:0] fa_1, fb_1, fbr1_1, fbr2_1;
  logic [4:0] wbrd_1;
  logic pcw_4, ifid_4, bub_4, flush_4, busy_4, wbwr_4;
  logic [1:0] fa_4, fb_4, fbr1_4, fbr2_4;
  logic [4:0] wbrd_4;
  out_t got1, got4;

  int checks = 0;
  int failures = 0;

  rec_t mp [2][3];
  int   mbusy [2];
  int   mlat [2];

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .MEM_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_branch_i(id_branch_i), .branch_eq_i(branch_eq_i),
    .pc_write_o(pcw_1), .if_id_write_o(ifid_1), .id_bubble_o(bub_1), .if_flush_o(flush_1),
    .fwd_a_o(fa_1), .fwd_b_o(fb_1), .fwd_br1_o(fbr1_1), .fwd_br2_o(fbr2_1),
    .mem_busy_o(busy_1), .memwb_rd_o(wbrd_1), .memwb_regwrite_o(wbwr_1)
  );

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .MEM_LAT(LAT4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_branch_i(id_branch_i), .branch_eq_i(branch_eq_i),
    .pc_write_o(pcw_4), .if_id_write_o(ifid_4), .id_bubble_o(bub_4), .if_flush_o(flush_4),
    .fwd_a_o(fa_4), .fwd_b_o(fb_4), .fwd_br1_o(fbr1_4), .fwd_br2_o(fbr2_4),
    .mem_busy_o(busy_4), .memwb_rd_o(wbrd_4), .memwb_regwrite_o(wbwr_4)
  );

  assign got1 = {pcw_1, ifid_1, bub_1, flush_1, fa_1, fb_1, fbr1_1, fbr2_1, busy_1, wbrd_1, wbwr_1};
  assign got4 = {pcw_4, ifid_4, bub_4, flush_4, fa_4, fb_4, fbr1_4, fbr2_4, busy_4, wbrd_4, wbwr_4};

  // ---------------- instruction builders ----------------
  function automatic stim_t mk(int rd, int a, int b, int u1, int u2, int wr, int ld,
                               int st, int br, int eq);
    stim_t s;
    s.rst = 1'b0;  s.start = 1'b1;
    s.rd = 5'(rd); s.rs1 = 5'(a); s.rs2 = 5'(b);
    s.u1 = 1'(u1); s.u2 = 1'(u2); s.wr = 1'(wr); s.ld = 1'(ld);
    s.st = 1'(st); s.br = 1'(br); s.eq = 1'(eq);
    return s;
  endfunction

  function automatic stim_t alu(int rd, int a, int b); return mk(rd, a, b, 1, 1, 1, 0, 0, 0, 0); endfunction
  function automatic stim_t lw(int rd, int a);         return mk(rd, a, 0, 1, 0, 1, 1, 0, 0, 0); endfunction
  function automatic stim_t sw(int a, int b);          return mk(0, a, b, 1, 1, 0, 0, 1, 0, 0); endfunction
  function automatic stim_t beq(int a, int b, int eq); return mk(0, a, b, 1, 1, 0, 0, 0, 1, eq); endfunction
  function automatic stim_t nop();                     return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction

  function automatic logic [8:0] ex(int pcw, int bub, int fl, int fa, int fb, int fbr1);
    return {1'(pcw), 1'(bub), 1'(fl), 2'(fa), 2'(fb), 2'(fbr1)};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic writes(rec_t r, logic [4:0] src, logic u);
    return u && r.v && r.wr && (r.rd != 5'd0) && (r.rd == src);
  endfunction

  // Closest producer wins; a load one stage ahead has no data yet for the ID comparator
  function automatic logic [1:0] pick(rec_t me, rec_t wb, logic [4:0] src, logic u, logic in_id);
    if (writes(me, src, u) && !(in_id && me.ld)) return 2'd2;
    if (writes(wb, src, u)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic out_t model_out(int m, stim_t s);
    out_t o;
    rec_t e, me, wb;
    logic frozen, hz, dep_e, dep_me;
    o = '0;
    if (s.rst) begin
      o.pcw  = s.start;
      o.ifid = s.start;
      return o;
    end
    e = mp[m][0]; me = mp[m][1]; wb = mp[m][2];
    frozen = (mbusy[m] > 0);
    dep_e  = writes(e, s.rs1, s.u1) || writes(e, s.rs2, s.u2);
    dep_me = writes(me, s.rs1, s.u1) || writes(me, s.rs2, s.u2);
    hz = (e.ld && dep_e) || (s.br && (dep_e || (me.ld && dep_me)));
    o.pcw   = s.start && !hz && !frozen;
    o.ifid  = o.pcw;
    o.bub   = hz && !frozen;
    o.flush = s.br && s.eq && !hz && !frozen;
    o.fa    = pick(me, wb, e.rs1, e.u1, 1'b0);
    o.fb    = pick(me, wb, e.rs2, e.u2, 1'b0);
    o.fbr1  = pick(me, wb, s.rs1, s.u1, 1'b1);
    o.fbr2  = pick(me, wb, s.rs2, s.u2, 1'b1);
    o.busy  = frozen;
    o.wb_rd = wb.rd;
    o.wb_wr = wb.v && wb.wr;
    return o;
  endfunction

  task automatic model_clear(int m);
    for (int k = 0; k < 3; k++) mp[m][k] = '0;
    mbusy[m] = 0;
  endtask

  task automatic model_step(int m, stim_t s);
    out_t o;
    rec_t n;
    if (s.rst) begin
      model_clear(m);
    end else if (mbusy[m] > 0) begin
      mbusy[m] = mbusy[m] - 1;
    end else begin
      o = model_out(m, s);
      n = '0;
      if (s.start && !o.bub) begin
        n.v = 1'b1; n.rd = s.rd; n.wr = s.wr; n.ld = s.ld; n.acc = s.ld || s.st;
        n.rs1 = s.rs1; n.rs2 = s.rs2; n.u1 = s.u1; n.u2 = s.u2;
      end
      mp[m][2] = mp[m][1];
      mp[m][1] = mp[m][0];
      mp[m][0] = n;
      if (mlat[m] > 1 && mp[m][1].v && mp[m][1].acc) mbusy[m] = mlat[m] - 1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check_out(string name, out_t got, out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_bit(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic check_v5(string name, logic [4:0] got, logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic apply(stim_t s);
    rst_i = s.rst; start_i = s.start;
    id_rs1_i = s.rs1; id_rs2_i = s.rs2; id_rd_i = s.rd;
    id_use_rs1_i = s.u1; id_use_rs2_i = s.u2;
    id_regwrite_i = s.wr; id_memread_i = s.ld; id_memwrite_i = s.st;
    id_branch_i = s.br; branch_eq_i = s.eq;
  endtask

  // Drive on the falling edge, sample just after, advance the model on the rising edge
  task automatic run_cycle(stim_t s, string tag, output out_t g1, output out_t g4);
    @(negedge clk);
    apply(s);
    #2;
    g1 = got1;
    g4 = got4;
    check_out({tag, "/lat1"}, g1, model_out(0, s));
    check_out({tag, "/lat4"}, g4, model_out(1, s));
    $display("cyc %s stim=%h lat1=%h lat4=%h", tag, s, g1, g4);
    @(posedge clk);
    model_step(0, s);
    model_step(1, s);
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst   = ($urandom_range(0, 99) == 0);
    s.start = ($urandom_range(0, 19) != 0);
    s.rs1   = 5'($urandom_range(0, 7));
    s.rs2   = 5'($urandom_range(0, 7));
    s.rd    = 5'($urandom_range(0, 7));
    s.u1    = 1'($urandom_range(0, 1));
    s.u2    = 1'($urandom_range(0, 1));
    s.wr    = 1'($urandom_range(0, 1));
    s.ld    = ($urandom_range(0, 3) == 0);
    s.st    = ($urandom_range(0, 5) == 0);
    s.br    = ($urandom_range(0, 3) == 0);
    s.eq    = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    row_t  tbl [29];
    out_t  g1, g4;
    stim_t rs;

    mlat[0] = 1;
    mlat[1] = LAT4;
    model_clear(0);
    model_clear(1);
    rs = nop();
    rs.rst = 1'b1;
    apply(rs);

    tbl[0]  = '{alu(5, 1, 2),   ex(1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{alu(6, 5, 1),   ex(1, 0, 0, 0, 0, 0)};
    tbl[2]  = '{nop(),          ex(1, 0, 0, 2, 0, 0)};
    tbl[3]  = '{alu(5, 1, 2),   ex(1, 0, 0, 0, 0, 0)};
    tbl[4]  = '{alu(10, 2, 3),  ex(1, 0, 0, 0, 0, 0)};
    tbl[5]  = '{alu(6, 5, 1),   ex(1, 0, 0, 0, 0, 2)};
    tbl[6]  = '{nop(),          ex(1, 0, 0, 1, 0, 0)};
    tbl[7]  = '{lw(7, 1),       ex(1, 0, 0, 0, 0, 0)};
    tbl[8]  = '{alu(8, 7, 7),   ex(0, 1, 0, 0, 0, 0)};
    tbl[9]  = '{alu(8, 7, 7),   ex(1, 0, 0, 0, 0, 0)};
    tbl[10] = '{nop(),          ex(1, 0, 0, 1, 1, 0)};
    tbl[11] = '{lw(3, 2),       ex(1, 0, 0, 0, 0, 0)};
    tbl[12] = '{beq(3, 0, 0),   ex(0, 1, 0, 0, 0, 0)};
    tbl[13] = '{beq(3, 0, 0),   ex(0, 1, 0, 0, 0, 0)};
    tbl[14] = '{beq(3, 0, 0),   ex(1, 0, 0, 0, 0, 1)};
    tbl[15] = '{alu(3, 1, 2),   ex(1, 0, 0, 0, 0, 0)};
    tbl[16] = '{beq(3, 0, 1),   ex(0, 1, 0, 0, 0, 0)};
    tbl[17] = '{beq(3, 0, 1),   ex(1, 0, 1, 0, 0, 2)};
    tbl[18] = '{beq(1, 2, 1),   ex(1, 0, 1, 1, 0, 0)};
    tbl[19] = '{nop(),          ex(1, 0, 0, 0, 0, 0)};
    tbl[20] = '{lw(4, 1),       ex(1, 0, 0, 0, 0, 0)};
    tbl[21] = '{beq(4, 0, 1),   ex(0, 1, 0, 0, 0, 0)};
    tbl[22] = '{beq(4, 0, 1),   ex(0, 1, 0, 0, 0, 0)};
    tbl[23] = '{beq(4, 0, 1),   ex(1, 0, 1, 0, 0, 1)};
    tbl[24] = '{alu(0, 1, 2),   ex(1, 0, 0, 0, 0, 0)};
    tbl[25] = '{alu(9, 0, 0),   ex(1, 0, 0, 0, 0, 0)};
    tbl[26] = '{lw(0, 1),       ex(1, 0, 0, 0, 0, 0)};
    tbl[27] = '{beq(0, 0, 0),   ex(1, 0, 0, 0, 0, 0)};
    tbl[28] = '{nop(),          ex(1, 0, 0, 0, 0, 0)};

    // reset state, with and without start
    rs = nop(); rs.rst = 1'b1; rs.start = 1'b0;
    run_cycle(rs, "rst_nostart", g1, g4);
    check_bit("rst_pcw_nostart", g1.pcw, 1'b0);
    rs.start = 1'b1;
    run_cycle(rs, "rst_start", g1, g4);
    check_bit("rst_pcw_start", g1.pcw, 1'b1);
    check_bit("rst_ifid_start", g1.ifid, 1'b1);
    check_bit("rst_busy", g4.busy, 1'b0);

    // directed hazard table on the single-cycle-memory instance
    for (int i = 0; i < 29; i++) begin
      run_cycle(tbl[i].s, $sformatf("tbl%0d", i), g1, g4);
      checks++;
      if ({g1.pcw, g1.bub, g1.flush, g1.fa, g1.fb, g1.fbr1} !== tbl[i].exp) begin
        failures++;
        $display("FAIL tbl_row%0d: got pcw/bub/flush/fa/fb/fbr1=%b expected=%b", i,
                 {g1.pcw, g1.bub, g1.flush, g1.fa, g1.fb, g1.fbr1}, tbl[i].exp);
      end
    end

    // store freezes the 4-cycle-latency instance for 3 cycles
    rs = nop(); rs.rst = 1'b1;
    run_cycle(rs, "frz_rst", g1, g4);
    run_cycle(alu(9, 1, 2), "frz_add", g1, g4);
    run_cycle(sw(1, 5), "frz_sw", g1, g4);
    run_cycle(nop(), "frz_nop", g1, g4);
    check_bit("frz_pre_busy", g4.busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(beq(1, 2, 1), $sformatf("frz%0d", i), g1, g4);
      check_bit($sformatf("frz%0d_busy", i), g4.busy, 1'b1);
      check_bit($sformatf("frz%0d_pcw", i), g4.pcw, 1'b0);
      check_bit($sformatf("frz%0d_flush", i), g4.flush, 1'b0);
      check_bit($sformatf("frz%0d_bub", i), g4.bub, 1'b0);
      check_v5($sformatf("frz%0d_wbrd", i), g4.wb_rd, 5'd9);
      check_bit($sformatf("frz%0d_wbwr", i), g4.wb_wr, 1'b1);
    end
    run_cycle(beq(1, 2, 1), "frz_end", g1, g4);
    check_bit("frz_end_busy", g4.busy, 1'b0);
    check_bit("frz_end_flush", g4.flush, 1'b1);
    run_cycle(nop(), "frz_adv", g1, g4);
    check_bit("frz_adv_wbwr", g4.wb_wr, 1'b0);
    check_bit("lat1_never_busy", g1.busy, 1'b0);

    // reset arriving mid-freeze
    run_cycle(sw(1, 5), "rfz_sw", g1, g4);
    run_cycle(nop(), "rfz_nop", g1, g4);
    run_cycle(nop(), "rfz_f1", g1, g4);
    check_bit("rfz_f1_busy", g4.busy, 1'b1);
    @(negedge clk);
    apply(nop());
    #2;
    check_bit("rfz_f2_busy", busy_4, 1'b1);
    rst_i = 1'b1;
    #1;
    check_bit("rfz_rst_busy", busy_4, 1'b0);
    check_bit("rfz_rst_pcw", pcw_4, 1'b1);
    $display("cyc rfz_async_rst busy4=%b pcw4=%b", busy_4, pcw_4);
    model_clear(0);
    model_clear(1);
    @(posedge clk);
    run_cycle(nop(), "rfz_after", g1, g4);
    check_bit("rfz_after_busy", g4.busy, 1'b0);

    // random traffic against the model on both instances
    for (int i = 0; i < 1500; i++) begin
      run_cycle(rnd_stim(), $sformatf("rnd%0d", i), g1, g4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
